cpu_clk_ctrl: RTL and testbench

Run/step/halt controller for the single-cycle MIPS demo core. It replaces a free-running divided clock with a single-cycle clock-enable pulse `cpu_en` on the board clock domain. The pulse is issued periodically in run mode, once per debounced button press in step mode, and never after the core signals halt. It sits between the board switches/buttons and the CPU's register-file, PC and data-memory write enables.

---
 rtl/cpu_clk_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cpu_clk_ctrl                                                |
// | Purpose  : Run/step/halt controller for the single-cycle MIPS demo     |
// |            core. Produces a one-cycle clock-enable pulse (cpu_en) on   |
// |            the board clock instead of a divided clock: periodically   |
// |            in RUN, once per debounced button press in STOP, and never  |
// |            once the core reports halt.                                 |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   clk          board clock, the only clock                             |
// |   rst          synchronous active-high reset                           |
// |   run_sw       run-mode switch (asynchronous), 1 = free-run            |
// |   step_btn     single-step push button (asynchronous, bouncy)          |
// |   halt         halt level from the CPU, synchronous to clk             |
// |   clr_halt     level request to leave HALT, synchronous to clk         |
// |   cpu_en       registered one-cycle CPU advance enable                 |
// |   state        FSM state: STOP=00 RUN=01 STEP=10 HALT=11               |
// |   halted       1 while state is HALT                                   |
// |   cycle_count  number of cpu_en pulses issued (wraps modulo 2^32)      |
// +------------------------------------------------------------------------+
module cpu_clk_ctrl #(
  parameter int DIV_COUNT       = 2500000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt,
  input  logic        clr_halt,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] cycle_count
);

  // Counter widths. The debounce width uses DEBOUNCE_CYCLES+1 so that a
  // value of 1 still yields a one-bit counter.
  localparam int TICK_W = $clog2(DIV_COUNT);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_COUNT - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  logic              run_meta_q, run_meta_d;
  logic              run_s_q,    run_s_d;
  logic              btn_meta_q, btn_meta_d;
  logic              btn_s_q,    btn_s_d;
  logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
  logic              btn_db_q,   btn_db_d;
  logic              btn_db_dly_q, btn_db_dly_d;
  logic [TICK_W-1:0] tick_q,     tick_d;
  state_t            state_q,    state_d;
  logic              cpu_en_q,   cpu_en_d;
  logic [31:0]       cycle_count_q, cycle_count_d;

  logic              step_pulse;
  logic              run_fire;

  // ------------------------------------------------------------------
  // Synchronizers: two flops per asynchronous input.
  // ------------------------------------------------------------------
  always_comb begin
    run_meta_d = run_sw;
    run_s_d    = run_meta_q;
    btn_meta_d = step_btn;
    btn_s_d    = btn_meta_q;
  end

  // ------------------------------------------------------------------
  // Debounce. The counter runs only while the synchronized button
  // disagrees with the accepted level; any agreement restarts it, so a
  // new level must persist for DEBOUNCE_CYCLES consecutive cycles.
  // ------------------------------------------------------------------
  always_comb begin
    db_cnt_d     = '0;
    btn_db_d     = btn_db_q;
    btn_db_dly_d = btn_db_q;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end
  end

  // Rising edge of the accepted level, one cycle after btn_db changes.
  assign step_pulse = btn_db_q & ~btn_db_dly_q;

  // ------------------------------------------------------------------
  // FSM next state. halt wins over every other input in every state.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (run_s_q) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (!run_s_q) begin
          state_d = ST_STOP;
        end
      end
      ST_STEP: begin
        state_d = halt ? ST_HALT : ST_STOP;
      end
      ST_HALT: begin
        if (clr_halt && !halt) begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Tick divider. Counts only while staying in RUN, so it reads 0 in
  // every other state and in the first RUN cycle.
  // ------------------------------------------------------------------
  always_comb begin
    tick_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_ONE;
    end
  end

  // Terminal tick in RUN fires only if the core is not halting and the
  // switch is still on; a falling run_s on the terminal tick suppresses it.
  assign run_fire = (state_q == ST_RUN) && (tick_q == TICK_LAST) &&
                    !halt && run_s_q;

  always_comb begin
    cpu_en_d      = run_fire || (state_q == ST_STOP && state_d == ST_STEP);
    cycle_count_d = cycle_count_q + {31'd0, cpu_en_q};
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      run_meta_q    <= 1'b0;
      run_s_q       <= 1'b0;
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_dly_q  <= 1'b0;
      tick_q        <= '0;
      state_q       <= ST_STOP;
      cpu_en_q      <= 1'b0;
      cycle_count_q <= 32'd0;
    end else begin
      run_meta_q    <= run_meta_d;
      run_s_q       <= run_s_d;
      btn_meta_q    <= btn_meta_d;
      btn_s_q       <= btn_s_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_dly_q  <= btn_db_dly_d;
      tick_q        <= tick_d;
      state_q       <= state_d;
      cpu_en_q      <= cpu_en_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign cpu_en      = cpu_en_q;
  assign state       = state_q;
  assign halted      = (state_q == ST_HALT);
  assign cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_cpu_clk_ctrl                                             |
// | Purpose  : Self-checking bench for cpu_clk_ctrl with DIV_COUNT=4 and   |
// |            DEBOUNCE_CYCLES=3. Stimulus pushes each expected cpu_en     |
// |            pulse (cycle number, cycle_count before the pulse) into a   |
// |            queue; a monitor pops an entry whenever cpu_en is seen.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_cpu_clk_ctrl;

  logic        clk;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic        halt;
  logic        clr_halt;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] cycle_count;

  localparam logic [1:0] S_STOP = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  cpu_clk_ctrl #(
    .DIV_COUNT       (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .halt        (halt),
    .clr_halt    (clr_halt),
    .cpu_en      (cpu_en),
    .state       (state),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the period following the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog: the run is a few hundred cycles; anything far longer is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required end by ~150", cyc);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every cpu_en pulse must match the head of the queue.
  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.cnt !== cycle_count) begin
          errors++;
          $display("FAIL pulse: got cycle %0d count %h, required cycle %0d count %h",
                   cyc, cycle_count, mon_e.cyc, mon_e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Change inputs inside cycle n (sampled at the edge that ends it).
  task automatic drive_at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Arrive at the falling edge inside cycle n.
  task automatic wait_neg(input int n);
    while (cyc < n || clk !== 1'b0) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [31:0] cnt);
    exp_t e;
    e.cyc = c;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    rst      = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    clr_halt = 1'b0;

    // Reset state
    drive_at(3);
    rst = 1'b0;
    wait_neg(3);
    chk("reset_state", 32'(state), 32'(S_STOP));
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_count", cycle_count, 32'd0);

    // Free run: switch on at 4 -> RUN at 7, pulses at 11, 15, 19
    drive_at(4);
    run_sw = 1'b1;
    push(11, 32'd0);
    push(15, 32'd1);
    push(19, 32'd2);
    wait_neg(6);
    chk("run_latency_stop", 32'(state), 32'(S_STOP));
    wait_neg(7);
    chk("run_entered", 32'(state), 32'(S_RUN));
    wait_neg(20);
    chk("run_count3", cycle_count, 32'd3);

    // Switch off so run_s falls on the terminal tick (cycle 22): no pulse at 23
    drive_at(20);
    run_sw = 1'b0;
    wait_neg(22);
    chk("run_before_stop", 32'(state), 32'(S_RUN));
    wait_neg(23);
    chk("run_stopped", 32'(state), 32'(S_STOP));
    wait_neg(30);
    chk("stop_count_held", cycle_count, 32'd3);

    // Bouncy press: two 2-cycle glitches, then stable high from 38
    drive_at(30); step_btn = 1'b1;
    drive_at(32); step_btn = 1'b0;
    drive_at(34); step_btn = 1'b1;
    drive_at(36); step_btn = 1'b0;
    drive_at(38); step_btn = 1'b1;
    push(44, 32'd3);
    wait_neg(43);
    chk("step_pre", 32'(state), 32'(S_STOP));
    wait_neg(44);
    chk("step_state", 32'(state), 32'(S_STEP));
    wait_neg(45);
    chk("step_post", 32'(state), 32'(S_STOP));
    drive_at(58); step_btn = 1'b0;
    wait_neg(66);
    chk("step_count", cycle_count, 32'd4);
    chk("step_hold_stop", 32'(state), 32'(S_STOP));

    // Halt on the terminal tick: RUN at 73, tick=3 at 76
    drive_at(70); run_sw = 1'b1;
    wait_neg(73);
    chk("halt_run", 32'(state), 32'(S_RUN));
    drive_at(76); halt = 1'b1;
    wait_neg(77);
    chk("halt_state", 32'(state), 32'(S_HALT));
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_no_en", 32'(cpu_en), 32'd0);
    drive_at(77); run_sw = 1'b0;
    drive_at(78); clr_halt = 1'b1;
    wait_neg(80);
    chk("halt_clr_blocked", 32'(state), 32'(S_HALT));
    drive_at(81); halt = 1'b0;
    wait_neg(82);
    chk("halt_cleared", 32'(state), 32'(S_STOP));
    chk("halt_halted_low", 32'(halted), 32'd0);
    drive_at(82); clr_halt = 1'b0;
    wait_neg(85);
    chk("halt_stay_stop", 32'(state), 32'(S_STOP));
    chk("halt_count", cycle_count, 32'd4);

    // Preload the pulse counter to all ones, then one step wraps it
    wait_neg(90);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    wait_neg(91);
    release dut.cycle_count_q;
    chk("preload", cycle_count, 32'hFFFF_FFFF);
    drive_at(95); step_btn = 1'b1;
    push(101, 32'hFFFF_FFFF);
    wait_neg(101);
    chk("wrap_step", 32'(state), 32'(S_STEP));
    wait_neg(102);
    chk("wrap_count", cycle_count, 32'd0);
    drive_at(105); step_btn = 1'b0;

    // Reset mid-RUN with tick=2 (RUN at 118, reset during 120)
    drive_at(115); run_sw = 1'b1;
    wait_neg(118);
    chk("rst_run", 32'(state), 32'(S_RUN));
    drive_at(120); rst = 1'b1;
    drive_at(121); rst = 1'b0;
    wait_neg(121);
    chk("rst_mid_state", 32'(state), 32'(S_STOP));
    chk("rst_mid_en", 32'(cpu_en), 32'd0);
    chk("rst_mid_halted", 32'(halted), 32'd0);
    chk("rst_mid_count", cycle_count, 32'd0);
    wait_neg(123);
    chk("rerun_latency", 32'(state), 32'(S_STOP));
    push(128, 32'd0);
    wait_neg(124);
    chk("rerun_entered", 32'(state), 32'(S_RUN));
    wait_neg(129);
    chk("rerun_count", cycle_count, 32'd1);
    drive_at(129); run_sw = 1'b0;
    wait_neg(132);
    chk("rerun_stop", 32'(state), 32'(S_STOP));
    wait_neg(140);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_count", cycle_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
